register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   RV32I integer register file: 2 combinational read ports, 1 clocked write port.
//   Sits directly downstream of instruction field extraction: consumes rs1/rs2/rd
//   indices (inst[19:15], inst[24:20], inst[11:7]); feeds ALU operands and store data.
//   Writeback from ALU/load/JAL path enters via wdata/we. x0 hardwired to zero.
// PARAMETERS
//   XLEN   32  data width of each register
//   NREGS  32  number of architectural registers (x0..x31)
//   AW     5   index width; must satisfy 2**AW == NREGS
// PORTS
//   clk       in   1     core clock, all state updates on rising edge
//   rst_n     in   1     asynchronous active-low reset
//   raddr1    in   AW    rs1 index
//   raddr2    in   AW    rs2 index
//   waddr     in   AW    rd index
//   we        in   1     write enable (RegWrite from control)
//   wdata     in   XLEN  writeback data
//   rdata1    out  XLEN  contents of x[raddr1]
//   rdata2    out  XLEN  contents of x[raddr2]
//   (REGFILE_DBG_EN only)
//   dbg_addr  in   AW    debug read index
//   dbg_data  out  XLEN  contents of x[dbg_addr]
//   wr_count  out  32    count of committed writes to x1..x31
// BEHAVIOUR
//   - Storage: NREGS x XLEN flops; entry 0 never written, always reads 0.
//   - Reset: rst_n low -> all registers 0 immediately (async), wr_count 0;
//     rdata1/rdata2/dbg_data therefore read 0 for every index while held.
//   - Reset mid-write: rst_n low overrides we; no write lands. First write
//     captured at first rising clk edge with rst_n high.
//   - Write: at posedge clk, if rst_n && we && waddr!=0 -> x[waddr] <= wdata.
//     we with waddr==0 is a silent no-op (no state change, no count).
//   - Read: purely combinational, zero latency; rdata = (raddr==0) ? 0 : x[raddr].
//   - Same-cycle read/write of same index: read returns OLD value; new value
//     visible the cycle after the edge. No internal bypass (a bypass would close
//     a combinational loop rdata->ALU->wdata in the single-cycle datapath).
//   - Both read ports may address the same register; independent, no conflict.
//   - Indices are full-range (AW bits == NREGS); no out-of-range case exists.
//   - No X propagation: every output defined from reset onward.
// CONFIGURATION
//   Macro REGFILE_DBG_EN:
//   - defined: adds dbg_addr/dbg_data third combinational read port (same x0
//     rule, same old-value semantics) and wr_count, incremented by 1 on each
//     posedge with rst_n && we && waddr!=0; wraps 0xFFFF_FFFF -> 0; reset 0.
//   - undefined: those three ports and the counter do not exist; remaining
//     port list and behaviour identical.
// TESTING
//   1 Reset: write x5=0xDEADBEEF, pulse rst_n low mid-cycle -> rdata1(raddr1=5)
//     reads 0 immediately, before next clk edge.
//   2 x0: we=1,waddr=0,wdata=0xFFFF_FFFF -> rdata1(raddr1=0)=0; wr_count unchanged.
//   3 Write/read: we=1,waddr=7,wdata=0x1234_5678 -> same cycle rdata2(raddr2=7)=
//     old value 0; next cycle rdata2=0x1234_5678.
//   4 Dual read: x3=0xA5A5_A5A5, x4=0x5A5A_5A5A, raddr1=3,raddr2=4 -> both
//     correct simultaneously; raddr1=raddr2=3 -> both 0xA5A5_A5A5.
//   5 Write gating: we=0,waddr=9,wdata=0x1 -> x9 stays 0; rst_n low with we=1,
//     waddr=9 at edge -> x9 stays 0.
//   6 REGFILE_DBG_EN: 10 writes to x1..x10 plus 2 to x0 -> wr_count=10;
//     dbg_addr=10 -> dbg_data equals 10th wdata; preload counter 0xFFFF_FFFF,
//     one write -> 0.

Source files
------------

// File: rtl/register_file.sv
// register_file: RV32I integer register file, two combinational read ports, one clocked write port
//   clk      in   1     core clock, writes land on rising edge
//   rst_n    in   1     asynchronous active-low reset, clears every register
//   raddr1   in   AW    rs1 index
//   raddr2   in   AW    rs2 index
//   waddr    in   AW    rd index
//   we       in   1     write enable
//   wdata    in   XLEN  writeback data
//   rdata1   out  XLEN  x[raddr1], zero for x0
//   rdata2   out  XLEN  x[raddr2], zero for x0
//   Optional, when REGFILE_DBG_EN is defined:
//   dbg_addr in   AW    debug read index
//   dbg_data out  XLEN  x[dbg_addr], zero for x0
//   wr_count out  32    committed writes to x1..x31, wraps at 2**32
module register_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    input  logic [AW-1:0]   waddr,
    input  logic            we,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
`ifdef REGFILE_DBG_EN
    ,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic [31:0]     wr_count
`endif
);
    logic [XLEN-1:0] regs [NREGS];
    logic            commit;
    assign commit = we && (waddr != '0);
    // Entry 0 is cleared on reset and never written; reads of x0 are also masked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[waddr] <= wdata;
        end
    end
    // No write-to-read bypass: a same-cycle read returns the pre-edge value,
    // which keeps rdata -> ALU -> wdata free of a combinational loop.
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
    end
`ifdef REGFILE_DBG_EN
    always_comb begin
        dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (commit) begin
            wr_count <= wr_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: vector table, directed corner sequences and random traffic against an array model
module tb_register_file;
    logic        clk;
    logic        rst_n;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
`ifdef REGFILE_DBG_EN
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] wr_count;
`endif

    int tests;
    int fails;
    logic [31:0] model [32];
    logic [31:0] model_count;

    register_file dut (
        .clk(clk),
        .rst_n(rst_n),
        .raddr1(raddr1),
        .raddr2(raddr2),
        .waddr(waddr),
        .we(we),
        .wdata(wdata),
        .rdata1(rdata1),
        .rdata2(rdata2)
`ifdef REGFILE_DBG_EN
        ,
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
        .wr_count(wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr1;
        logic [4:0]  raddr2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        model_count = 32'd0;
    endtask

    // Advance one full cycle; the model commits only what a legal write would.
    task automatic step();
        @(posedge clk);
        if (rst_n && we && waddr != 5'd0) begin
            model[waddr] = wdata;
            model_count = model_count + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        we = w;
        waddr = wa;
        wdata = wd;
        raddr1 = r1;
        raddr2 = r2;
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_clear();
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
`ifdef REGFILE_DBG_EN
        dbg_addr = 5'd0;
`endif
        @(negedge clk);
        for (int i = 1; i < 32; i += 6) begin
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            check("reset_rdata1", rdata1, 32'd0);
            check("reset_rdata2", rdata2, 32'd0);
        end
`ifdef REGFILE_DBG_EN
        check("reset_wr_count", wr_count, 32'd0);
`endif
        rst_n = 1'b1;

        // Reset lands asynchronously, before any clock edge.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        check("x5_written", rdata1, 32'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1 check("async_reset_x5", rdata1, 32'd0);
        model_clear();

        // Write attempted while reset is held must not land.
        drive(1'b1, 5'd9, 32'h0BADF00D, 5'd9, 5'd9);
        step();
        rst_n = 1'b1;
        drive(1'b0, 5'd9, 32'h1, 5'd9, 5'd0);
        check("reset_blocks_write", rdata1, 32'd0);
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        check("we0_blocks_write", rdata1, 32'd0);

        vecs[0]  = '{1'b1, 5'd7,  32'h12345678, 5'd0,  5'd7,  32'h0,        32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h12345678, 32'h12345678};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'h12345678};
        vecs[4]  = '{1'b1, 5'd3,  32'hA5A5A5A5, 5'd3,  5'd4,  32'h0,        32'h0};
        vecs[5]  = '{1'b1, 5'd4,  32'h5A5A5A5A, 5'd3,  5'd4,  32'hA5A5A5A5, 32'h0};
        vecs[6]  = '{1'b0, 5'd9,  32'h1,        5'd3,  5'd4,  32'hA5A5A5A5, 32'h5A5A5A5A};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd7,  32'h0,        32'h12345678};
        vecs[9]  = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd1,  32'h0,        32'h0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D};
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr1, vecs[i].raddr2);
            check($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].exp1);
            check($sformatf("vec%0d_rdata2", i), rdata2, vecs[i].exp2);
            step();
        end

`ifdef REGFILE_DBG_EN
        rst_n = 1'b0;
        #1 model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            if (i == 4 || i == 8) drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
            else drive(1'b1, 5'(i < 4 ? i : (i < 8 ? i - 1 : i - 2)), 32'h1000 + 32'(i), 5'd0, 5'd0);
            step();
        end
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        dbg_addr = 5'd10;
        #1;
        check("wr_count_10", wr_count, 32'd10);
        check("dbg_x10", dbg_data, 32'h1000 + 32'd12);
        dbg_addr = 5'd0;
        #1 check("dbg_x0", dbg_data, 32'd0);
`endif

        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
`ifdef REGFILE_DBG_EN
            dbg_addr = 5'($urandom_range(0, 31));
            #1;
            check("rand_dbg", dbg_data, model_read(dbg_addr));
            check("rand_count", wr_count, model_count);
`endif
            check("rand_rdata1", rdata1, model_read(raddr1));
            check("rand_rdata2", rdata2, model_read(raddr2));
            if ($urandom_range(0, 39) == 0) begin
                #1 rst_n = 1'b0;
                #1 check("rand_reset", rdata1 | rdata2, 32'd0);
                model_clear();
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
